alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Alarm sequencing controller for the digital timer. It sits between the time-compare logic (`match`) and the speaker driver. It arms on the alarm toggle switch and starts ringing on a rising edge of `match`. While ringing it produces a 1 Hz beep cadence, and it handles snooze, stop and automatic ring timeout, all counted in seconds from the timer's one-second tick.

## Interface
- `SNOOZE_SEC`, 300: seconds from a snooze press until ringing resumes.
- `RING_TIMEOUT_SEC`, 60: seconds of continuous ringing before auto-stop.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event; further snooze presses are ignored.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `toggle_switch` input 1: alarm enable level (1 = alarm on).
- `match` input 1: level, high while alarm time equals current time.
- `sec_tick` input 1: single-cycle pulse, once per second.
- `snooze_btn` input 1: debounced level; acted on at its rising edge.
- `stop_btn` input 1: debounced level; acted on at its rising edge.
- `speaker_out` output 1: speaker drive (beep cadence while ringing).
- `ringing` output 1: state is RING.
- `snoozed` output 1: state is SNOOZE.
- `snooze_cnt` output clog2(MAX_SNOOZE+1): snoozes used in the current alarm event.

## Operation
- States: IDLE, ARMED, RING, SNOOZE.
- Internal edge registers `match_q`, `snooze_q` and `stop_q` hold the previous-cycle values.
  - A rising edge is present when `x & ~x_q`.
- Per-cycle priority, highest first:
  1. reset;
  2. `toggle_switch == 0`;
  3. `stop` edge;
  4. `snooze` edge;
  5. `match` edge / `sec_tick` events.
- `toggle_switch == 0` in any state: go to IDLE, and clear all counters, `beep_phase` and `snooze_cnt`.
- IDLE: when `toggle_switch == 1`, go to ARMED.
- ARMED: a `match` rising edge goes to RING. On entry, `ring_cnt = 0` and `beep_phase = 1`.
- RING:
  - `stop` edge: go to ARMED and clear `snooze_cnt`.
  - `snooze` edge with `snooze_cnt < MAX_SNOOZE`: go to SNOOZE, `snooze_cnt++`, and load `snz_cnt = SNOOZE_SEC`.
  - `snooze` edge with `snooze_cnt == MAX_SNOOZE`: ignored; the state stays RING.
  - `sec_tick`: toggle `beep_phase` and increment `ring_cnt`. If `ring_cnt == RING_TIMEOUT_SEC-1` on that tick, go to ARMED and clear `snooze_cnt`.
- SNOOZE:
  - `stop` edge: go to ARMED and clear `snooze_cnt`.
  - `sec_tick`: decrement `snz_cnt`. If `snz_cnt == 1` on that tick, go to RING with `ring_cnt = 0` and `beep_phase = 1`.
  - `match` edges are ignored.
  - `snooze` edges are ignored.
- Outputs are decoded from registered state only, with no combinational input-to-output path:
  - `speaker_out = (state==RING) & beep_phase`;
  - `ringing = (state==RING)`;
  - `snoozed = (state==SNOOZE)`.
- Counter widths: `clog2(max(SNOOZE_SEC, RING_TIMEOUT_SEC)+1)`. Counters never wrap; they are always reloaded on state entry.
- `match` held high for a whole minute causes exactly one trigger. Re-trigger requires `match` to fall and rise again.

## Timing
- Reset, cycle 0: state IDLE; `speaker_out`, `ringing`, `snoozed` and `snooze_cnt` are all 0; all edge registers are 0.
- Trigger: `match` rises at clock edge N, with state ARMED and `match_q = 0`. From edge N+1, `ringing = 1` and `speaker_out = 1`.
- `match` already high on the first cycle after reset with the switch on: the state reaches ARMED at edge 1. Because `match_q` is now 1, no trigger occurs until the next rising edge of `match`.
- Beep cadence: `speaker_out` toggles on the cycle after each `sec_tick` while in RING. Ringing gives 1 s on / 1 s off, starting with on.
- Snooze latency: exactly SNOOZE_SEC `sec_tick` pulses after the snooze edge. RING is entered the cycle after the SNOOZE_SEC-th tick.
- Timeout: RING exits the cycle after the RING_TIMEOUT_SEC-th tick counted in RING.
- Simultaneous events in one cycle: resolved by the priority list in Operation.
- A snooze edge together with the timeout tick: snooze wins, and the state goes to SNOOZE.
- A stop edge together with a snooze edge: stop wins.
- `reset` asserted mid-ring or mid-snooze: all outputs are 0 on the next cycle, and the state is IDLE.

## Test plan
- **Reset and arm:** hold `reset` 2 cycles with `toggle_switch = 1`, then pulse `match` 0→1. Expect `ringing = 1` and `speaker_out = 1` one cycle after the edge. Hold `match` high 200 cycles; expect no re-trigger after a stop.
- **Cadence and timeout (`RING_TIMEOUT_SEC = 4`):** trigger, then apply 4 `sec_tick` pulses. Expect `speaker_out` pattern 1,0,1,0 and then `ringing = 0`, state ARMED, `snooze_cnt = 0`.
- **Snooze (`SNOOZE_SEC = 3`, `MAX_SNOOZE = 2`):**
  - Snooze during RING: expect `snoozed = 1` and `snooze_cnt = 1`.
  - After 3 ticks: expect `ringing = 1`.
  - Snooze twice more: the second snooze is accepted (`snooze_cnt = 2`); the third is ignored (stays RING).
- **Stop:** stop edge in RING, and in a separate run in SNOOZE. Expect ARMED next cycle with `snooze_cnt = 0` and `speaker_out = 0`.
- **Switch off and priority:**
  - Drop `toggle_switch` while ringing: expect IDLE and all outputs 0 next cycle.
  - Same-cycle stop and snooze edges: expect ARMED.
  - Snooze on the timeout tick: expect SNOOZE.
- **Reset mid-snooze:** assert `reset` with `snz_cnt = 2`. Expect all outputs 0 next cycle. With the switch on, the state re-enters ARMED after reset.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-compare/button logic and the alarm sequencer.
// The master side drives the alarm inputs; the slave side is the controller.
interface alarm_ctrl_if #(
    parameter int unsigned MAX_SNOOZE = 3
);
    logic                                toggle_switch;
    logic                                match;
    logic                                sec_tick;
    logic                                snooze_btn;
    logic                                stop_btn;
    logic                                speaker_out;
    logic                                ringing;
    logic                                snoozed;
    logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_cnt;

    modport master (
        output toggle_switch, match, sec_tick, snooze_btn, stop_btn,
        input  speaker_out, ringing, snoozed, snooze_cnt
    );

    modport slave (
        input  toggle_switch, match, sec_tick, snooze_btn, stop_btn,
        output speaker_out, ringing, snoozed, snooze_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arms on the switch, rings on a match rising edge, and
// handles 1 Hz beep cadence, snooze, stop and ring timeout in seconds.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic         clk,
    input  logic         reset,
    alarm_ctrl_if.slave  bus
);
    localparam int unsigned CNT_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned SW      = $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {IDLE, ARMED, RING, SNOOZE} state_t;

    state_t          state;
    logic            match_q;
    logic            snooze_q;
    logic            stop_q;
    logic            beep_phase;
    logic [CW-1:0]   ring_cnt;
    logic [CW-1:0]   snz_cnt;
    logic [SW-1:0]   snooze_cnt;

    logic match_rise;
    logic snooze_rise;
    logic stop_rise;

    assign match_rise  = bus.match      & ~match_q;
    assign snooze_rise = bus.snooze_btn & ~snooze_q;
    assign stop_rise   = bus.stop_btn   & ~stop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            match_q    <= 1'b0;
            snooze_q   <= 1'b0;
            stop_q     <= 1'b0;
            beep_phase <= 1'b0;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            snooze_cnt <= '0;
        end else begin
            match_q  <= bus.match;
            snooze_q <= bus.snooze_btn;
            stop_q   <= bus.stop_btn;

            if (!bus.toggle_switch) begin
                state      <= IDLE;
                beep_phase <= 1'b0;
                ring_cnt   <= '0;
                snz_cnt    <= '0;
                snooze_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;

                    ARMED: begin
                        if (match_rise) begin
                            state      <= RING;
                            ring_cnt   <= '0;
                            beep_phase <= 1'b1;
                        end
                    end

                    RING: begin
                        // A refused snooze (quota spent) falls through so the tick still counts.
                        if (stop_rise) begin
                            state      <= ARMED;
                            snooze_cnt <= '0;
                        end else if (snooze_rise && (snooze_cnt < SW'(MAX_SNOOZE))) begin
                            state      <= SNOOZE;
                            snooze_cnt <= snooze_cnt + 1'b1;
                            snz_cnt    <= CW'(SNOOZE_SEC);
                        end else if (bus.sec_tick) begin
                            beep_phase <= ~beep_phase;
                            ring_cnt   <= ring_cnt + 1'b1;
                            if (ring_cnt == CW'(RING_TIMEOUT_SEC - 1)) begin
                                state      <= ARMED;
                                snooze_cnt <= '0;
                            end
                        end
                    end

                    SNOOZE: begin
                        if (stop_rise) begin
                            state      <= ARMED;
                            snooze_cnt <= '0;
                        end else if (bus.sec_tick) begin
                            snz_cnt <= snz_cnt - 1'b1;
                            if (snz_cnt == CW'(1)) begin
                                state      <= RING;
                                ring_cnt   <= '0;
                                beep_phase <= 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.speaker_out = (state == RING) & beep_phase;
    assign bus.ringing     = (state == RING);
    assign bus.snoozed     = (state == SNOOZE);
    assign bus.snooze_cnt  = snooze_cnt;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed vector table, a long match-hold sequence,
// and randomized stimulus against a seconds-level behavioural model.
module tb_alarm_ctrl;
    localparam int unsigned T_SNZ  = 3;
    localparam int unsigned T_RING = 4;
    localparam int unsigned N_SNZ  = 2;

    logic clk;
    logic reset;

    alarm_ctrl_if #(.MAX_SNOOZE(N_SNZ)) bus ();

    alarm_ctrl #(
        .SNOOZE_SEC      (T_SNZ),
        .RING_TIMEOUT_SEC(T_RING),
        .MAX_SNOOZE      (N_SNZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs {rst,tog,match,tick,snooze,stop}; outputs {speaker,ringing,snoozed,cnt[1:0]}
    typedef struct {
        logic [5:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: alarm life-cycle tracked in whole seconds.
    typedef enum {M_OFF, M_WAIT, M_BELL, M_NAP} mmode_t;
    mmode_t m_mode;
    int     m_rung;
    int     m_nap_left;
    int     m_used;
    logic   m_pm, m_ps, m_pp;

    task automatic model_step(input logic [5:0] in);
        logic r, tg, mt, tk, sz, sp;
        logic rm, rs, rp;
        {r, tg, mt, tk, sz, sp} = in;
        rm = mt && !m_pm;
        rs = sz && !m_ps;
        rp = sp && !m_pp;
        if (r) begin
            m_mode = M_OFF; m_used = 0; m_rung = 0; m_nap_left = 0;
            m_pm = 0; m_ps = 0; m_pp = 0;
            return;
        end
        if (!tg) begin
            m_mode = M_OFF; m_used = 0; m_rung = 0; m_nap_left = 0;
        end else begin
            case (m_mode)
                M_OFF:  m_mode = M_WAIT;
                M_WAIT: if (rm) begin m_mode = M_BELL; m_rung = 0; end
                M_BELL: begin
                    if (rp) begin
                        m_mode = M_WAIT; m_used = 0;
                    end else if (rs && m_used < int'(N_SNZ)) begin
                        m_mode = M_NAP; m_used++; m_nap_left = T_SNZ;
                    end else if (tk) begin
                        m_rung++;
                        if (m_rung == int'(T_RING)) begin m_mode = M_WAIT; m_used = 0; end
                    end
                end
                M_NAP: begin
                    if (rp) begin
                        m_mode = M_WAIT; m_used = 0;
                    end else if (tk) begin
                        m_nap_left--;
                        if (m_nap_left == 0) begin m_mode = M_BELL; m_rung = 0; end
                    end
                end
                default: m_mode = M_OFF;
            endcase
        end
        m_pm = mt; m_ps = sz; m_pp = sp;
    endtask

    function automatic logic [4:0] model_out();
        logic bell;
        bell = (m_mode == M_BELL);
        return {bell && (m_rung % 2 == 0), bell, m_mode == M_NAP, 2'(m_used)};
    endfunction

    task automatic apply(input logic [5:0] in, output logic [4:0] got);
        {reset, bus.toggle_switch, bus.match, bus.sec_tick, bus.snooze_btn, bus.stop_btn} = in;
        @(posedge clk);
        model_step(in);
        #1;
        got = {bus.speaker_out, bus.ringing, bus.snoozed, bus.snooze_cnt};
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] got, input logic [4:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s #%0d: got {spk,ring,snz,cnt}=%b, want %b", name, idx, got, want);
        end
    endtask

    task automatic add(input logic [5:0] in, input logic [4:0] exp);
        vec_t v;
        v.in = in;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] got;
        logic [5:0] in;
        logic lm, ls, lp, tg;

        m_mode = M_OFF; m_rung = 0; m_nap_left = 0; m_used = 0;
        m_pm = 0; m_ps = 0; m_pp = 0;
        {reset, bus.toggle_switch, bus.match, bus.sec_tick, bus.snooze_btn, bus.stop_btn} = 6'b110000;

        // reset, arm, trigger, cadence 1,0,1,0 then timeout
        add(6'b1_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b1_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b0_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b0_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b0_0_0_00);
        // re-trigger, snooze, 3-second snooze latency, quota
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_0_1_0, 5'b0_0_1_01);
        add(6'b0_1_0_1_1_0, 5'b0_0_1_01);
        add(6'b0_1_1_1_0_0, 5'b0_0_1_01);
        add(6'b0_1_1_1_0_0, 5'b1_1_0_01);
        add(6'b0_1_1_0_1_0, 5'b0_0_1_10);
        add(6'b0_1_1_1_1_0, 5'b0_0_1_10);
        add(6'b0_1_1_1_0_0, 5'b0_0_1_10);
        add(6'b0_1_1_1_0_0, 5'b1_1_0_10);
        add(6'b0_1_1_0_1_0, 5'b1_1_0_10);
        add(6'b0_1_1_0_0_1, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b0_0_0_00);
        // switch off while ringing
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_0_1_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        // stop and snooze together
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_0_1_1, 5'b0_0_0_00);
        // snooze on the timeout tick
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b0_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_1_0_0, 5'b0_1_0_00);
        add(6'b0_1_1_1_1_0, 5'b0_0_1_01);
        // reset mid-snooze, then arm with match already high
        add(6'b0_1_1_1_0_0, 5'b0_0_1_01);
        add(6'b0_1_1_0_0_0, 5'b0_0_1_01);
        add(6'b1_1_1_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b0_0_0_00);
        // stop while snoozed, reset while ringing
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b0_1_1_0_1_0, 5'b0_0_1_01);
        add(6'b0_1_1_0_0_1, 5'b0_0_0_00);
        add(6'b0_1_0_0_0_0, 5'b0_0_0_00);
        add(6'b0_1_1_0_0_0, 5'b1_1_0_00);
        add(6'b1_1_1_0_0_0, 5'b0_0_0_00);

        foreach (tbl[i]) begin
            apply(tbl[i].in, got);
            check("table", i, got, tbl[i].exp);
        end

        // match held high across arming: never a trigger
        for (int i = 0; i < 200; i++) begin
            apply(6'b0_1_1_0_0_0, got);
            check("match_hold", i, got, 5'b0_0_0_00);
        end
        // a stop edge while armed has no effect, then match must fall and rise
        apply(6'b0_1_1_0_0_1, got);
        check("stop_armed", 0, got, 5'b0_0_0_00);
        apply(6'b0_1_0_0_0_0, got);
        check("match_fall", 0, got, 5'b0_0_0_00);
        apply(6'b0_1_1_0_0_0, got);
        check("retrigger", 0, got, 5'b1_1_0_00);

        // randomized run against the model
        apply(6'b1_1_0_0_0_0, got);
        check("rand_reset", 0, got, model_out());
        lm = 0; ls = 0; lp = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)  lm = ~lm;
            if ($urandom_range(5) == 0)  ls = ~ls;
            if ($urandom_range(19) == 0) lp = ~lp;
            tg = ($urandom_range(59) != 0);
            in = {($urandom_range(399) == 0), tg, lm, ($urandom_range(2) == 0), ls, lp};
            apply(in, got);
            check("random", i, got, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
